// File: rtl/stack_unit.sv
// Stack pointer, address and data generation for the controller's two-byte
// push/pop handshake; also captures popped return address and flags.
module stack_unit #(
  parameter logic [7:0] STACK_TOP   = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'hE0,
  parameter int unsigned PC_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stack_op_ongoing,
  input  logic                push_or_pop,
  input  logic                bus_grant,
  output logic                stack_op_end,
  input  logic [PC_WIDTH-1:0] pc_in,
  input  logic [5:0]          flags_in,
  output logic [7:0]          stack_addr,
  output logic [7:0]          stack_wr_data,
  input  logic [7:0]          stack_rd_data,
  output logic [PC_WIDTH-1:0] ret_pc,
  output logic [5:0]          ret_flags,
  output logic [7:0]          sp,
  output logic                stack_err
);

  logic       cnt;
  logic       dir_q;
  logic       dir;
  logic       advance;
  logic [7:0] pc_ext;

  // Direction is latched on the first granted byte so the frame cannot flip mid-way.
  assign dir     = cnt ? dir_q : push_or_pop;
  assign advance = stack_op_ongoing && bus_grant;
  assign stack_op_end = advance && cnt;

  always_comb begin
    pc_ext = '0;
    pc_ext[PC_WIDTH-1:0] = pc_in;
  end

  always_comb begin
    stack_addr    = '0;
    stack_wr_data = '0;
    if (stack_op_ongoing) begin
      if (dir) begin
        stack_addr    = sp;
        stack_wr_data = cnt ? {2'b00, flags_in} : pc_ext;
      end else begin
        stack_addr = sp + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= STACK_TOP;
      cnt       <= 1'b0;
      dir_q     <= 1'b0;
      ret_pc    <= '0;
      ret_flags <= '0;
      stack_err <= 1'b0;
    end else if (advance) begin
      cnt <= ~cnt;
      if (!cnt) dir_q <= push_or_pop;
      if (dir) begin
        sp <= sp - 8'd1;
        if (sp < STACK_LIMIT) stack_err <= 1'b1;
      end else begin
        sp <= sp + 8'd1;
        if (sp == STACK_TOP) stack_err <= 1'b1;
        if (cnt) ret_pc    <= stack_rd_data[PC_WIDTH-1:0];
        else     ret_flags <= stack_rd_data[5:0];
      end
    end else if (!stack_op_ongoing && cnt) begin
      // Abandoned frame: bytes already moved stay moved.
      cnt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit with hand-computed expectations.
module tb_stack_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       stack_op_ongoing;
  logic       push_or_pop;
  logic       bus_grant;
  logic       stack_op_end;
  logic [7:0] pc_in;
  logic [5:0] flags_in;
  logic [7:0] stack_addr;
  logic [7:0] stack_wr_data;
  logic [7:0] stack_rd_data;
  logic [7:0] ret_pc;
  logic [5:0] ret_flags;
  logic [7:0] sp;
  logic       stack_err;

  int n_checks = 0;
  int n_errors = 0;

  stack_unit #(.STACK_TOP(8'hFF), .STACK_LIMIT(8'hE0), .PC_WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .stack_op_ongoing(stack_op_ongoing),
    .push_or_pop     (push_or_pop),
    .bus_grant       (bus_grant),
    .stack_op_end    (stack_op_end),
    .pc_in           (pc_in),
    .flags_in        (flags_in),
    .stack_addr      (stack_addr),
    .stack_wr_data   (stack_wr_data),
    .stack_rd_data   (stack_rd_data),
    .ret_pc          (ret_pc),
    .ret_flags       (ret_flags),
    .sp              (sp),
    .stack_err       (stack_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stack_op_ongoing = 1'b0;
    bus_grant = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stack_op_ongoing = 1'b0;
    push_or_pop = 1'b0;
    bus_grant = 1'b0;
    pc_in = 8'h00;
    flags_in = 6'h00;
    stack_rd_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    settle();

    // Reset state
    check("rst_sp", sp, 8'hFF);
    check("rst_err", stack_err, 1'b0);
    check("rst_ret_pc", ret_pc, 8'h00);
    check("rst_ret_flags", ret_flags, 6'h00);
    check("rst_end", stack_op_end, 1'b0);
    check("rst_addr", stack_addr, 8'h00);

    // Push 0x42 / 0x15, grant continuous
    stack_op_ongoing = 1'b1; push_or_pop = 1'b1; bus_grant = 1'b1;
    pc_in = 8'h42; flags_in = 6'h15;
    settle();
    check("push_b0_addr", stack_addr, 8'hFF);
    check("push_b0_wdata", stack_wr_data, 8'h42);
    check("push_b0_end", stack_op_end, 1'b0);
    tick();
    check("push_b1_addr", stack_addr, 8'hFE);
    check("push_b1_wdata", stack_wr_data, 8'h15);
    check("push_b1_end", stack_op_end, 1'b1);
    tick();
    stack_op_ongoing = 1'b0; bus_grant = 1'b0;
    settle();
    check("push_sp", sp, 8'hFD);
    check("idle_wdata", stack_wr_data, 8'h00);
    check("idle_end", stack_op_end, 1'b0);

    // Pop back: FE=0x15 then FF=0x42
    stack_op_ongoing = 1'b1; push_or_pop = 1'b0; bus_grant = 1'b1;
    stack_rd_data = 8'h15;
    settle();
    check("pop_b0_addr", stack_addr, 8'hFE);
    check("pop_b0_wdata", stack_wr_data, 8'h00);
    check("pop_b0_end", stack_op_end, 1'b0);
    tick();
    stack_rd_data = 8'h42;
    settle();
    check("pop_b1_addr", stack_addr, 8'hFF);
    check("pop_b1_end", stack_op_end, 1'b1);
    tick();
    stack_op_ongoing = 1'b0; bus_grant = 1'b0;
    settle();
    check("pop_ret_flags", ret_flags, 6'h15);
    check("pop_ret_pc", ret_pc, 8'h42);
    check("pop_sp", sp, 8'hFF);
    check("pop_err", stack_err, 1'b0);

    // Stalled push, direction toggled after byte0
    stack_op_ongoing = 1'b1; push_or_pop = 1'b1; bus_grant = 1'b0;
    pc_in = 8'h33; flags_in = 6'h2A;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall0_addr", stack_addr, 8'hFF);
      check("stall0_wdata", stack_wr_data, 8'h33);
      check("stall0_sp", sp, 8'hFF);
      check("stall0_end", stack_op_end, 1'b0);
      tick();
    end
    bus_grant = 1'b1;
    settle();
    check("stall_b0_end", stack_op_end, 1'b0);
    tick();
    bus_grant = 1'b0; push_or_pop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall1_addr", stack_addr, 8'hFE);
      check("stall1_wdata", stack_wr_data, 8'h2A);
      check("stall1_sp", sp, 8'hFE);
      check("stall1_end", stack_op_end, 1'b0);
      tick();
    end
    bus_grant = 1'b1;
    settle();
    check("stall_b1_addr", stack_addr, 8'hFE);
    check("stall_b1_end", stack_op_end, 1'b1);
    check("hold_ret_pc", ret_pc, 8'h42);
    tick();
    stack_op_ongoing = 1'b0; bus_grant = 1'b0;
    settle();
    check("stall_sp", sp, 8'hFD);
    check("stall_err", stack_err, 1'b0);

    // Underflow: pop from empty stack wraps to 0x01
    do_reset();
    stack_op_ongoing = 1'b1; push_or_pop = 1'b0; bus_grant = 1'b1;
    stack_rd_data = 8'h07;
    tick();
    check("uf_err_b0", stack_err, 1'b1);
    check("uf_sp_b0", sp, 8'h00);
    check("uf_addr_b1", stack_addr, 8'h01);
    tick();
    stack_op_ongoing = 1'b0; bus_grant = 1'b0;
    settle();
    check("uf_sp", sp, 8'h01);
    check("uf_ret_flags", ret_flags, 6'h07);

    // Overflow: 16 frames bring SP to 0xDF cleanly, next push byte flags it
    do_reset();
    stack_op_ongoing = 1'b1; push_or_pop = 1'b1; bus_grant = 1'b1;
    pc_in = 8'h11; flags_in = 6'h22;
    for (int i = 0; i < 32; i++) tick();
    check("of_sp_df", sp, 8'hDF);
    check("of_err_clear", stack_err, 1'b0);
    tick();
    check("of_err_set", stack_err, 1'b1);
    check("of_sp_de", sp, 8'hDE);

    // Abort with cnt==1: no end pulse, next frame restarts at byte0
    stack_op_ongoing = 1'b0; bus_grant = 1'b0;
    settle();
    check("abort_end", stack_op_end, 1'b0);
    tick();
    stack_op_ongoing = 1'b1; bus_grant = 1'b0;
    settle();
    check("abort_restart_wdata", stack_wr_data, 8'h11);
    check("abort_sp", sp, 8'hDE);

    // Reset mid-frame, with grant asserted during the reset cycle
    do_reset();
    stack_op_ongoing = 1'b1; push_or_pop = 1'b1; bus_grant = 1'b1;
    pc_in = 8'h5A; flags_in = 6'h3C;
    tick();
    check("mid_sp_b0", sp, 8'hFE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("mid_rst_sp", sp, 8'hFF);
    check("mid_rst_addr", stack_addr, 8'hFF);
    check("mid_rst_wdata", stack_wr_data, 8'h5A);
    check("mid_rst_end", stack_op_end, 1'b0);
    tick();
    check("mid_b1_addr", stack_addr, 8'hFE);
    check("mid_b1_wdata", stack_wr_data, 8'h3C);
    check("mid_b1_end", stack_op_end, 1'b1);
    tick();
    stack_op_ongoing = 1'b0; bus_grant = 1'b0;
    settle();
    check("mid_sp", sp, 8'hFD);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Responder side of the CPU controller's stack-operation handshake (stack_op_ongoing / push_or_pop / stack_op_end).
- Owns the stack pointer and generates the data-memory address and write data for each stack byte. Captures popped bytes for return-address and flag restore.
- Sits between the controller FSM and the data-memory bus mux. The controller still drives data_mem_wr/rd and bus_req; this block supplies the address and data, and counts granted bytes.

Parameters:
- STACK_TOP, 8'hFF, reset value of SP; highest stack address; SP==STACK_TOP means the stack is empty.
- STACK_LIMIT, 8'hE0, lowest usable stack address; a push with SP below this is an overflow.
- PC_WIDTH, 8, program counter width (must be ≤8).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stack_op_ongoing  in  1  controller is in its stack-op state
- push_or_pop  in  1  1=PUSH, 0=POP; sampled at the first byte only
- bus_grant  in  1  current stack byte completes this cycle
- stack_op_end  out  1  final byte granted this cycle (combinational)
- pc_in  in  PC_WIDTH  return address to push
- flags_in  in  6  {IF,IE,V,N,C,Z} to push
- stack_addr  out  8  data-memory address for the current byte
- stack_wr_data  out  8  data-memory write data
- stack_rd_data  in  8  data-memory read data, valid when bus_grant=1
- ret_pc  out  PC_WIDTH  popped return address
- ret_flags  out  6  popped flags
- sp  out  8  current stack pointer
- stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (sync): sp=STACK_TOP, byte counter cnt=0, dir_q=0, ret_pc=0, ret_flags=0, stack_err=0. stack_op_end is 0 while not ongoing.
- A frame is 2 bytes; cnt is 1 bit (0 = first byte, 1 = second byte).
- Direction used: dir = (cnt==0) ? push_or_pop : dir_q. When the first byte is granted, dir_q <= push_or_pop. Changes on push_or_pop after that point are ignored.
- PUSH (post-decrement):
  - stack_addr = sp.
  - byte0 = {{(8-PC_WIDTH){0}}, pc_in}.
  - byte1 = {2'b00, flags_in}.
  - Each granted byte: sp <= sp-1.
- POP (pre-increment):
  - stack_addr = sp+1.
  - byte0 read → ret_flags <= stack_rd_data[5:0].
  - byte1 read → ret_pc <= stack_rd_data[PC_WIDTH-1:0].
  - Each granted byte: sp <= sp+1.
- stack_wr_data is 0 when dir=POP or not ongoing. stack_addr is 0 when not ongoing.
- Byte advance requires stack_op_ongoing && bus_grant. With ongoing=1 and bus_grant=0 (bus stall), hold all state and outputs; there is no timeout.
- On a granted byte with cnt==0: cnt <= 1.
- On a granted byte with cnt==1: stack_op_end=1 in that same cycle, and cnt <= 0.
- Frame latency is exactly 2 granted cycles, with no extra cycles added.
- ret_pc and ret_flags update only on granted pop bytes and hold until the next pop. A completed pop's values are valid from the cycle after stack_op_end.
- SP arithmetic is mod 256 with no saturation. The transfer always executes, even when stack_err is set.
- stack_err is set (sticky until rst) on either of:
  - a granted push byte with sp < STACK_LIMIT;
  - a granted pop byte with sp == STACK_TOP (underflow).
- Abort: if stack_op_ongoing drops while cnt==1, cnt <= 0. Bytes already moved are not rolled back. No stack_op_end is generated.
- rst mid-frame overrides everything. The partial frame is discarded.
- rst and grant in the same cycle: rst wins, and no register updates from the grant.

Test Plan:
- Reset → sp=0xFF, stack_err=0, ret_pc=0, ret_flags=0, stack_op_end=0, stack_addr=0.
- Push pc_in=0x42, flags_in=0x15 with bus_grant high continuously → cycle 1: addr 0xFF, wdata 0x42; cycle 2: addr 0xFE, wdata 0x15, stack_op_end=1; then sp=0xFD.
- Pop from sp=0xFD, memory FE=0x15, FF=0x42 → addr 0xFE then 0xFF, stack_op_end on the 2nd grant. Next cycle: ret_flags=0x15, ret_pc=0x42, sp=0xFF, stack_err=0.
- Push with bus_grant low for 3 cycles before each byte → addr, wdata and sp stable during the stalls. stack_op_end occurs only on the 2nd grant. Toggling push_or_pop to 0 after byte0 still writes flags at 0xFE.
- Pop at sp=0xFF (empty) → stack_err=1 after the first granted byte; sp ends 0x01 (wrap). A push from sp=0xDF → stack_err=1.
- rst asserted after byte0 of a push → next cycle sp=0xFF, cnt=0. A following full push writes 0xFF and 0xFE normally.
